issue_queue_sched_ctrl: RTL

- Controller for one issue-queue bank.
- Owns per-entry valid, source-tag and source-ready state.
- Allocates free entries to in-order enqueue lanes, applies wakeup broadcasts, builds the ready mask for the oldest-first age-matrix selector and turns its grants into issue handshakes and dequeues.
- Sits between rename/dispatch and the functional-unit issue ports.
- Drives the age matrix's enq/deq/sel/vld inputs and consumes its result mask.

---
 rtl/issue_queue_sched_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/issue_queue_sched_ctrl.sv
// rtl/issue_queue_sched_ctrl.sv - issue-queue bank controller: allocation, wakeup, select handshakes
module issue_queue_sched_ctrl #(
    parameter int EntryCount = 4,
    parameter int EnqWidth   = 2,
    parameter int SelWidth   = 2,
    parameter int WakeWidth  = 2,
    parameter int TagWidth   = 6
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush_i,
    input  logic [EnqWidth-1:0]                        enq_valid_i,
    output logic [EnqWidth-1:0]                        enq_ready_o,
    input  logic [EnqWidth*2*TagWidth-1:0]             enq_src_tag_i,
    input  logic [EnqWidth*2-1:0]                      enq_src_rdy_i,
    input  logic [EnqWidth*TagWidth-1:0]               enq_dst_tag_i,
    input  logic [WakeWidth-1:0]                       wake_valid_i,
    input  logic [WakeWidth*TagWidth-1:0]              wake_tag_i,
    output logic [EnqWidth-1:0]                        age_enq_fire_o,
    output logic [EnqWidth*EntryCount-1:0]             age_enq_mask_o,
    output logic                                       age_deq_fire_o,
    output logic [EntryCount-1:0]                      age_deq_mask_o,
    output logic [EntryCount-1:0]                      age_sel_mask_o,
    output logic [EntryCount-1:0]                      age_entry_vld_o,
    input  logic [SelWidth*EntryCount-1:0]             age_result_mask_i,
    output logic [SelWidth-1:0]                        iss_valid_o,
    input  logic [SelWidth-1:0]                        iss_ready_i,
    output logic [SelWidth*TagWidth-1:0]               iss_dst_tag_o,
    output logic [SelWidth*$clog2(EntryCount)-1:0]     iss_entry_idx_o,
    output logic [$clog2(EntryCount+1)-1:0]            occupancy_o
);

    localparam int IdxW = $clog2(EntryCount);
    localparam int OccW = $clog2(EntryCount+1);

    logic [EntryCount-1:0]                    valid_q, valid_d;
    logic [EntryCount-1:0][1:0]               src_rdy_q, src_rdy_d;
    logic [EntryCount-1:0][1:0][TagWidth-1:0] src_tag_q, src_tag_d;
    logic [EntryCount-1:0][TagWidth-1:0]      dst_tag_q, dst_tag_d;
    logic [OccW-1:0]                          occupancy_q, occupancy_d;

    logic [OccW-1:0]                          free_cnt;
    logic [EntryCount-1:0]                    avail;
    logic                                     prev_ok;
    logic                                     found;
    logic [EnqWidth-1:0]                      enq_ready;
    logic [EnqWidth-1:0]                      enq_fire;
    logic [EnqWidth-1:0][EntryCount-1:0]      lane_mask;
    logic [SelWidth-1:0][TagWidth-1:0]        iss_tag;
    logic [SelWidth-1:0][IdxW-1:0]            iss_idx;
    logic [SelWidth-1:0]                      iss_valid;
    logic [EntryCount-1:0]                    deq_mask;
    logic [EntryCount-1:0]                    grant;

    function automatic logic wake_hit(input logic [TagWidth-1:0]           tag,
                                      input logic [WakeWidth-1:0]          wv,
                                      input logic [WakeWidth*TagWidth-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WakeWidth; w++) begin
            if (wv[w] && (wt[w*TagWidth +: TagWidth] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Lanes are served in order from the lowest free entries; a non-requesting lane skips nothing.
    always_comb begin
        free_cnt  = '0;
        avail     = ~valid_q;
        prev_ok   = 1'b1;
        found     = 1'b0;
        enq_ready = '0;
        enq_fire  = '0;
        lane_mask = '0;
        for (int e = 0; e < EntryCount; e++) begin
            free_cnt = free_cnt + {{(OccW-1){1'b0}}, ~valid_q[e]};
        end
        for (int j = 0; j < EnqWidth; j++) begin
            enq_ready[j] = (32'(free_cnt) > j) && !flush_i && !rst;
            enq_fire[j]  = enq_valid_i[j] && enq_ready[j] && prev_ok;
            prev_ok      = enq_fire[j] || !enq_valid_i[j];
            found        = 1'b0;
            if (enq_fire[j]) begin
                for (int e = 0; e < EntryCount; e++) begin
                    if (avail[e] && !found) begin
                        lane_mask[j][e] = 1'b1;
                        found           = 1'b1;
                    end
                end
            end
            avail = avail & ~lane_mask[j];
        end
    end

    // Grants are assumed disjoint, so OR-muxing the stored tag and index is exact.
    always_comb begin
        iss_tag   = '0;
        iss_idx   = '0;
        iss_valid = '0;
        deq_mask  = '0;
        grant     = '0;
        for (int p = 0; p < SelWidth; p++) begin
            grant        = age_result_mask_i[p*EntryCount +: EntryCount];
            iss_valid[p] = |grant;
            for (int e = 0; e < EntryCount; e++) begin
                if (grant[e]) begin
                    iss_tag[p] = iss_tag[p] | dst_tag_q[e];
                    iss_idx[p] = iss_idx[p] | IdxW'(e);
                end
            end
            if (iss_valid[p] && iss_ready_i[p]) deq_mask = deq_mask | grant;
        end
    end

    always_comb begin
        valid_d     = valid_q & ~deq_mask;
        src_rdy_d   = src_rdy_q;
        src_tag_d   = src_tag_q;
        dst_tag_d   = dst_tag_q;
        occupancy_d = '0;
        for (int e = 0; e < EntryCount; e++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[e] && wake_hit(src_tag_q[e][s], wake_valid_i, wake_tag_i))
                    src_rdy_d[e][s] = 1'b1;
            end
        end
        for (int j = 0; j < EnqWidth; j++) begin
            for (int e = 0; e < EntryCount; e++) begin
                if (lane_mask[j][e]) begin
                    valid_d[e]   = 1'b1;
                    dst_tag_d[e] = enq_dst_tag_i[j*TagWidth +: TagWidth];
                    for (int s = 0; s < 2; s++) begin
                        src_tag_d[e][s] = enq_src_tag_i[(j*2+s)*TagWidth +: TagWidth];
                        src_rdy_d[e][s] = enq_src_rdy_i[j*2+s] ||
                            wake_hit(enq_src_tag_i[(j*2+s)*TagWidth +: TagWidth],
                                     wake_valid_i, wake_tag_i);
                    end
                end
            end
        end
        if (flush_i) valid_d = '0;
        for (int e = 0; e < EntryCount; e++) begin
            occupancy_d = occupancy_d + {{(OccW-1){1'b0}}, valid_d[e]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            src_rdy_q   <= '0;
            occupancy_q <= '0;
        end else begin
            valid_q     <= valid_d;
            src_rdy_q   <= src_rdy_d;
            occupancy_q <= occupancy_d;
        end
    end

    always_ff @(posedge clk) begin
        src_tag_q <= src_tag_d;
        dst_tag_q <= dst_tag_d;
    end

    always_comb begin
        age_sel_mask_o = '0;
        for (int e = 0; e < EntryCount; e++) begin
            age_sel_mask_o[e] = valid_q[e] & src_rdy_q[e][0] & src_rdy_q[e][1];
        end
    end

    assign enq_ready_o     = enq_ready;
    assign age_enq_fire_o  = enq_fire;
    assign age_enq_mask_o  = lane_mask;
    assign age_deq_mask_o  = deq_mask;
    assign age_deq_fire_o  = |deq_mask;
    assign age_entry_vld_o = valid_q;
    assign iss_valid_o     = iss_valid;
    assign iss_dst_tag_o   = iss_tag;
    assign iss_entry_idx_o = iss_idx;
    assign occupancy_o     = occupancy_q;

endmodule
